multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; the block SHALL be non-parameterised.
REQ-002 clk  in  1  system clock, all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 op  in  7  instr[6:0]; func3  in  3  instr[14:12]; func7  in  7  instr[31:25].
REQ-005 zero  in  1  ALU result == 0; sign  in  1  ALU result bit 31.
REQ-006 pc_write, ir_write, mem_write, reg_write  out  1 each  write strobes.
REQ-007 adr_src  out  1  0 = PC, 1 = result; wd_sel  out  1  0 = result, 1 = PC.
REQ-008 alu_src_a  out  2  0 = PC, 1 = old PC, 2 = reg A, 3 = zero.
REQ-009 alu_src_b  out  2  0 = reg B, 1 = immediate, 2 = constant 4, 3 = zero.
REQ-010 result_src  out  2  0 = ALU-out register, 1 = data register, 2 = live ALU result, 3 = immediate.
REQ-011 alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
REQ-012 illegal_op  out  1  sticky flag: an unsupported instruction was decoded.

Function
REQ-013 Moore FSM; pc_write in BRANCH is the only Mealy output.
REQ-014 Any output not listed for a state SHALL be 0 (alu_control 000).
REQ-015 FETCH: adr_src=0, ir_write=1, a=0, b=2, ADD, result_src=2, pc_write=1 -> DECODE.
REQ-016 DECODE: a=1, b=1, ADD (branch/JAL target into ALU-out).
REQ-017 DECODE next state, by op:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 or 0100011 -> MEM_ADR
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- anything else -> ERROR
REQ-018 EXEC_R: a=2, b=0.
- func3 000: ADD when func7[5]=0, SUB when func7[5]=1
- 111 AND; 110 OR; 010 SLT
- any other func3 -> ERROR instead of ALU_WB
REQ-019 EXEC_I: a=2, b=1.
- func3 000 ADD, 111 AND, 110 OR, 010 SLT; func7 ignored
- any other func3 -> ERROR
REQ-020 ALU_WB: result_src=0, wd_sel=0, reg_write=1 -> FETCH.
REQ-021 MEM_ADR: a=2, b=1, ADD.
- op 0000011 -> MEM_READ
- op 0100011 -> MEM_WRITE
REQ-022 MEM_READ: adr_src=1, result_src=0 -> MEM_WB.
REQ-023 MEM_WB: result_src=1, wd_sel=0, reg_write=1 -> FETCH.
REQ-024 MEM_WRITE: adr_src=1, result_src=0, mem_write=1 -> FETCH.
REQ-025 BRANCH: a=2, b=0, SUB, result_src=0; pc_write = taken; -> FETCH.
- func3 000 BEQ: taken = zero
- 001 BNE: taken = !zero
- 100 BLT: taken = sign
- 101 BGE: taken = !sign
- any other func3 -> ERROR, pc_write=0
REQ-026 JAL: result_src=0, pc_write=1, wd_sel=1, reg_write=1 (rd gets PC+4) -> FETCH.
REQ-027 JALR: a=2, b=1, ADD, result_src=2, pc_write=1, wd_sel=1, reg_write=1 -> FETCH; target bit 0 is not cleared.
REQ-028 LUI: result_src=3, wd_sel=0, reg_write=1 -> FETCH.
REQ-029 ERROR: all strobes 0, illegal_op=1; the state holds until reset.
REQ-030 Latency in cycles: R/I-ALU 4, LW 5, SW 4, branch 3, JAL 3, JALR 3, LUI 3.

Reset
REQ-031 rst=0 SHALL asynchronously force state to FETCH and illegal_op to 0.
REQ-032 While rst=0, all four write strobes SHALL be forced to 0; selects show FETCH values.
REQ-033 Reset asserted mid-instruction SHALL abandon it; the first edge after release SHALL perform FETCH.

Configuration
REQ-034 Macro BRANCH_EXT_EN: when defined, BNE/BLT/BGE are supported per REQ-025.
REQ-035 Without BRANCH_EXT_EN, only BEQ is supported; branch func3 != 000 -> ERROR with no PC write.

Verification
REQ-036 ADD: op=0110011, func3=000, func7=0.
- States FETCH, DECODE, EXEC_R, ALU_WB, FETCH
- alu_control=000 in EXEC_R; reg_write=1 only in ALU_WB
REQ-037 LW, op=0000011:
- mem_write=0 throughout
- adr_src=1 in MEM_READ; result_src=1 with reg_write=1 in MEM_WB; 5 cycles total
REQ-038 BNE, func3=001 (BRANCH_EXT_EN defined):
- zero=0 -> pc_write=1 in BRANCH
- zero=1 -> pc_write=0 in BRANCH
- Without the macro: illegal_op=1 and state ERROR
REQ-039 op=1111111:
- ERROR reached after DECODE; illegal_op stays 1 for 10 cycles
- rst pulse returns the FSM to FETCH with illegal_op=0
REQ-040 rst=0 asserted during MEM_WRITE:
- mem_write drops to 0 immediately (asynchronously)
- After release, ir_write=1 on the first cycle

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I-subset datapath: one state per datapath step.
// Optional feature macro: BRANCH_EXT_EN adds BNE/BLT/BGE; otherwise only BEQ is legal.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       sign,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic       wd_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic       illegal_op
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_READ,
        S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_JALR, S_LUI, S_ERROR
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       func_ok, branch_ok, branch_taken;
    logic [2:0] alu_func;
    logic       pc_write_s, ir_write_s, mem_write_s, reg_write_s;
    logic       unused_inputs;

    assign unused_inputs = ^{func7[6], func7[4:0], sign};

    // ALU function shared by EXEC_R and EXEC_I; func7[5] selects SUB only for R-type.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        func_ok  = 1'b1;
        alu_func = ALU_ADD;
        case (func3)
            3'b000:  alu_func = (state_q == S_EXEC_R && func7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_func = ALU_AND;
            3'b110:  alu_func = ALU_OR;
            3'b010:  alu_func = ALU_SLT;
            default: func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        branch_ok    = 1'b0;
        branch_taken = 1'b0;
`ifdef BRANCH_EXT_EN
        case (func3)
            3'b000:  begin branch_ok = 1'b1; branch_taken = zero;  end
            3'b001:  begin branch_ok = 1'b1; branch_taken = !zero; end
            3'b100:  begin branch_ok = 1'b1; branch_taken = sign;  end
            3'b101:  begin branch_ok = 1'b1; branch_taken = !sign; end
            default: begin branch_ok = 1'b0; branch_taken = 1'b0;  end
        endcase
`else
        branch_ok    = (func3 == 3'b000);
        branch_taken = branch_ok && zero;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = func_ok ? S_ALU_WB : S_ERROR;
            S_MEM_ADR:          state_d = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:         state_d = S_MEM_WB;
            S_BRANCH:           state_d = branch_ok ? S_FETCH : S_ERROR;
            S_ERROR:            state_d = S_ERROR;
            default:            state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_ERROR);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of the current state; only BRANCH's pc_write looks at live flags.
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        wd_sel      = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        result_src  = 2'd0;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
            end
            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'd2;
                alu_control = alu_func;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                alu_control = alu_func;
            end
            S_ALU_WB:   reg_write_s = 1'b1;
            S_MEM_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            S_MEM_READ: adr_src = 1'b1;
            S_MEM_WB: begin
                result_src  = 2'd1;
                reg_write_s = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'd2;
                alu_control = ALU_SUB;
                pc_write_s  = branch_ok && branch_taken;
            end
            S_JAL: begin
                pc_write_s  = 1'b1;
                wd_sel      = 1'b1;
                reg_write_s = 1'b1;
            end
            S_JALR: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                result_src  = 2'd2;
                pc_write_s  = 1'b1;
                wd_sel      = 1'b1;
                reg_write_s = 1'b1;
            end
            S_LUI: begin
                result_src  = 2'd3;
                reg_write_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset directly so they drop without waiting for a clock.
    assign pc_write   = pc_write_s  & rst;
    assign ir_write   = ir_write_s  & rst;
    assign mem_write  = mem_write_s & rst;
    assign reg_write  = reg_write_s & rst;
    assign illegal_op = illegal_q;

endmodule
